// File: rtl/pkt_sched_pkg.sv
// Shared definitions for the packet scheduler.
// Contents:
//   state_e   - scheduler FSM states (IDLE, ARB, XFER, DROP)
//   cfg_t     - per-source {k,len} configuration record at the default data width
//   CNT_W     - width of the optional statistics counters
//   cnt_inc   - wrapping increment for the statistics counters
package pkt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2,
        DROP = 2'd3
    } state_e;

    // Field layout of one source's cfg word; k sits in the upper half.
    localparam int CFG_DW = 8;
    typedef struct packed {
        logic [CFG_DW-1:0] k;
        logic [CFG_DW-1:0] len;
    } cfg_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req   [NS-1:0] - request vector
//   ptr   [SW-1:0] - highest-priority index for this decision
//   grant [SW-1:0] - first requesting index at or after ptr (wrapping)
//   valid          - at least one request is present
module rr_arbiter #(
    parameter  int NS = 4,
    localparam int SW = $clog2(NS)
) (
    input  logic [NS-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          valid
);

    // scan NS positions starting at ptr; the first requester wins
    always_comb begin
        logic [SW:0] pos;
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < NS; i++) begin
            pos = {1'b0, ptr} + (SW+1)'(i);
            if (pos >= (SW+1)'(NS)) begin
                pos = pos - (SW+1)'(NS);
            end else begin
                pos = pos;
            end
            if (!valid && req[pos[SW-1:0]]) begin
                valid = 1'b1;
                grant = pos[SW-1:0];
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/pkt_sched.sv
// Packet scheduler: round-robin selection among NS AXI-stream sources, one
// packet at a time, with a per-packet length limit (beats past len are
// discarded) and the granted source's {k,len} presented on m_cfg.
// Ports:
//   clk, rst (sync, active-low)
//   s_tdata/s_tvalid/s_tlast/s_tready - per-source streams
//   s_cfg  - per-source {k,len}
//   m_tdata/m_tvalid/m_tlast/m_tready - output stream (zero-latency pass-through)
//   m_cfg, m_src - cfg and index of the granted source, latched at arbitration
//   cfg_err - sticky, set when a granted cfg has k > len
// Optional build macro PKT_SCHED_STATS_EN adds pkt_cnt (per-source completed
// packets) and drop_cnt (entries into DROP).
module pkt_sched
    import pkt_sched_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int NS = 4,
    localparam int SW = $clog2(NS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NS*DW-1:0]   s_tdata,
    input  logic [NS-1:0]      s_tvalid,
    input  logic [NS-1:0]      s_tlast,
    output logic [NS-1:0]      s_tready,
    input  logic [NS*2*DW-1:0] s_cfg,
    output logic [DW-1:0]      m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    output logic [2*DW-1:0]    m_cfg,
    output logic [SW-1:0]      m_src,
    output logic               cfg_err
`ifdef PKT_SCHED_STATS_EN
    ,
    output logic [NS*CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]    drop_cnt
`endif
);

    state_e          state_r, state_nxt_s;
    logic [SW-1:0]   ptr_r, next_ptr_s;
    logic [DW-1:0]   beat_r;
    logic [2*DW-1:0] m_cfg_r;
    logic [SW-1:0]   m_src_r;
    logic            cfg_err_r;

    logic [SW-1:0]   arb_grant_s;
    logic            arb_valid_s;
    logic [2*DW-1:0] gcfg_s;
    logic [DW-1:0]   len_s;
    logic            len_hit_s;
    logic            grant_en_s;
    logic            advance_s;
    logic            beat_inc_s;
    logic            drop_en_s;

    rr_arbiter #(.NS(NS)) u_arb (
        .req   (s_tvalid),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    assign gcfg_s     = s_cfg[arb_grant_s*(2*DW) +: 2*DW];
    assign len_s      = m_cfg_r[DW-1:0];
    // length limit reached on the beat currently offered (len==0 is unlimited)
    assign len_hit_s  = (len_s != '0) && (beat_r == (len_s - DW'(1)));
    assign next_ptr_s = (m_src_r == SW'(NS-1)) ? '0 : (m_src_r + SW'(1));

    assign m_cfg   = m_cfg_r;
    assign m_src   = m_src_r;
    assign cfg_err = cfg_err_r;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next state, stream muxing and bookkeeping strobes; all outputs forced low in reset
    always_comb begin
        state_nxt_s = state_r;
        s_tready    = '0;
        m_tdata     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        grant_en_s  = 1'b0;
        advance_s   = 1'b0;
        beat_inc_s  = 1'b0;
        drop_en_s   = 1'b0;
        if (!rst) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|s_tvalid) begin
                        state_nxt_s = ARB;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARB: begin
                    if (arb_valid_s) begin
                        grant_en_s  = 1'b1;
                        state_nxt_s = XFER;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                XFER: begin
                    m_tdata           = s_tdata[m_src_r*DW +: DW];
                    m_tvalid          = s_tvalid[m_src_r];
                    m_tlast           = s_tlast[m_src_r] | len_hit_s;
                    s_tready[m_src_r] = m_tready;
                    if (s_tvalid[m_src_r] && m_tready) begin
                        beat_inc_s = 1'b1;
                        // a real end-of-packet wins over the length limit
                        if (s_tlast[m_src_r]) begin
                            advance_s   = 1'b1;
                            state_nxt_s = IDLE;
                        end else if (len_hit_s) begin
                            drop_en_s   = 1'b1;
                            state_nxt_s = DROP;
                        end else begin
                            state_nxt_s = XFER;
                        end
                    end else begin
                        state_nxt_s = XFER;
                    end
                end
                DROP: begin
                    s_tready[m_src_r] = 1'b1;
                    if (s_tvalid[m_src_r] && s_tlast[m_src_r]) begin
                        advance_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // grant bookkeeping: pointer, beat count, latched cfg/source, sticky cfg error
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r     <= '0;
            beat_r    <= '0;
            m_cfg_r   <= '0;
            m_src_r   <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            if (grant_en_s) begin
                m_cfg_r <= gcfg_s;
                m_src_r <= arb_grant_s;
                if (gcfg_s[2*DW-1:DW] > gcfg_s[DW-1:0]) begin
                    cfg_err_r <= 1'b1;
                end else begin
                    cfg_err_r <= cfg_err_r;
                end
            end else begin
                m_cfg_r   <= m_cfg_r;
                m_src_r   <= m_src_r;
                cfg_err_r <= cfg_err_r;
            end
            if (state_r == ARB) begin
                beat_r <= '0;
            end else if (beat_inc_s) begin
                beat_r <= beat_r + DW'(1);
            end else begin
                beat_r <= beat_r;
            end
            if (advance_s) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

`ifdef PKT_SCHED_STATS_EN
    // wrapping statistics, updated on the XFER/DROP exit edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (advance_s) begin
                pkt_cnt[m_src_r*CNT_W +: CNT_W] <= cnt_inc(pkt_cnt[m_src_r*CNT_W +: CNT_W]);
            end else begin
                pkt_cnt <= pkt_cnt;
            end
            if (drop_en_s) begin
                drop_cnt <= cnt_inc(drop_cnt);
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_sched.sv
module tb_pkt_sched;
    localparam int NS   = 4;
    localparam int DW   = 8;
    localparam int MAXP = 4;
    localparam int MAXB = 12;

    logic               clk;
    logic               rst;
    logic [NS*DW-1:0]   s_tdata;
    logic [NS-1:0]      s_tvalid;
    logic [NS-1:0]      s_tlast;
    logic [NS-1:0]      s_tready;
    logic [NS*2*DW-1:0] s_cfg;
    logic [DW-1:0]      m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready;
    logic [2*DW-1:0]    m_cfg;
    logic [1:0]         m_src;
    logic               cfg_err;
`ifdef PKT_SCHED_STATS_EN
    logic [NS*16-1:0]   pkt_cnt;
    logic [15:0]        drop_cnt;
`endif

    pkt_sched #(.DW(DW), .NS(NS)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .s_cfg(s_cfg),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .m_cfg(m_cfg), .m_src(m_src), .cfg_err(cfg_err)
`ifdef PKT_SCHED_STATS_EN
        , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // traffic description: per source a list of packets
    int              npk [NS];
    int              nb  [NS][MAXP];
    logic [2*DW-1:0] pcfg[NS][MAXP];
    logic [2*DW-1:0] acfg[NS][MAXP];
    logic [DW-1:0]   pdata[NS][MAXP][MAXB];

    // reference model state
    typedef struct {
        int              src;
        logic [DW-1:0]   data;
        logic            last;
        logic [2*DW-1:0] cfg;
    } exp_t;
    exp_t exp_q[$];
    int   model_ptr;
    bit   exp_cfg_err;
    int   exp_drop_beats;
    int   exp_drop_cnt;
    int   exp_pkt[NS];

    task automatic clear_traffic();
        for (int i = 0; i < NS; i++) npk[i] = 0;
    endtask

    task automatic clear_model();
        model_ptr = 0; exp_cfg_err = 1'b0; exp_drop_cnt = 0;
        for (int i = 0; i < NS; i++) exp_pkt[i] = 0;
    endtask

    task automatic add_pkt(input int src, input int n, input logic [DW-1:0] k,
                           input logic [DW-1:0] len, input logic [2*DW-1:0] alt);
        int p;
        p = npk[src];
        nb[src][p] = n; pcfg[src][p] = {k, len}; acfg[src][p] = alt;
        for (int b = 0; b < n; b++) pdata[src][p][b] = DW'($urandom_range(0, 255));
        npk[src] = p + 1;
    endtask

    // transaction-level model: round-robin packet order, length truncation, sticky error
    task automatic build_expected();
        int nxt[NS];
        int g, p, n, ln, kk, outn;
        bit any;
        logic [DW-1:0] lv, kv;
        exp_t e;
        exp_q.delete();
        exp_drop_beats = 0;
        for (int i = 0; i < NS; i++) nxt[i] = 0;
        while (1) begin
            any = 0;
            for (int i = 0; i < NS; i++) if (nxt[i] < npk[i]) any = 1;
            if (!any) break;
            g = -1;
            for (int j = 0; j < NS; j++) begin
                int c;
                c = (model_ptr + j) % NS;
                if (g < 0 && nxt[c] < npk[c]) g = c;
            end
            p = nxt[g]; n = nb[g][p];
            lv = pcfg[g][p][DW-1:0]; kv = pcfg[g][p][2*DW-1:DW];
            ln = int'(lv); kk = int'(kv);
            outn = (ln == 0 || n <= ln) ? n : ln;
            for (int b = 0; b < outn; b++) begin
                e.src = g; e.data = pdata[g][p][b]; e.last = (b == outn - 1); e.cfg = pcfg[g][p];
                exp_q.push_back(e);
            end
            if (outn < n) begin
                exp_drop_beats += n - outn;
                exp_drop_cnt++;
            end
            if (kk > ln) exp_cfg_err = 1'b1;
            exp_pkt[g]++;
            model_ptr = (g + 1) % NS;
            nxt[g]++;
        end
    endtask

    // ready_mode: 0 = always ready, 1 = toggle 1,0,1,0, 2 = random
    task automatic run_traffic(input int ready_mode, input bit throttle, input bit check_gap, input string tag);
        int cur_p[NS], cur_b[NS];
        int cyc, last_cyc, drops_seen;
        bit prev_last, pending, mhs;
        exp_t e;
        build_expected();
        for (int i = 0; i < NS; i++) begin cur_p[i] = 0; cur_b[i] = 0; end
        cyc = 0; last_cyc = 0; drops_seen = 0; prev_last = 0; pending = 1;
        while (pending && cyc < 3000) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (cur_p[i] < npk[i]) begin
                    s_tvalid[i] = !(throttle && cur_b[i] > 0 && $urandom_range(0, 3) == 0);
                    s_tdata[i*DW +: DW] = pdata[i][cur_p[i]][cur_b[i]];
                    s_tlast[i] = (cur_b[i] == nb[i][cur_p[i]] - 1);
                    s_cfg[i*2*DW +: 2*DW] = (cur_b[i] > 0) ? acfg[i][cur_p[i]] : pcfg[i][cur_p[i]];
                end else begin
                    s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
                    s_tdata[i*DW +: DW] = '0; s_cfg[i*2*DW +: 2*DW] = '0;
                end
            end
            case (ready_mode)
                0: m_tready = 1'b1;
                1: m_tready = (cyc % 2 == 0);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            mhs = m_tvalid && m_tready;
            if (m_tvalid && exp_q.size() > 0) begin
                checks++;
                if (s_tready[exp_q[0].src] !== m_tready) begin
                    errors++;
                    $display("FAIL %s ready_mirror cyc=%0d got s_tready=%b want %b", tag, cyc, s_tready, m_tready);
                end
            end
            if (mhs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat cyc=%0d got src=%0d data=%h want no beat", tag, cyc, m_src, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_src, m_tdata, m_tlast, m_cfg} !== {2'(e.src), e.data, e.last, e.cfg}) begin
                        errors++;
                        $display("FAIL %s beat cyc=%0d got src=%0d data=%h last=%b cfg=%h want src=%0d data=%h last=%b cfg=%h",
                                 tag, cyc, m_src, m_tdata, m_tlast, m_cfg, e.src, e.data, e.last, e.cfg);
                    end
                end
                if (check_gap && prev_last) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL %s gap got %0d cycles want 3", tag, cyc - last_cyc);
                    end
                end
                prev_last = m_tlast; last_cyc = cyc;
            end
            for (int i = 0; i < NS; i++) begin
                if (s_tvalid[i] && s_tready[i] && cur_p[i] < npk[i]) begin
                    if (!mhs) drops_seen++;
                    cur_b[i]++;
                    if (cur_b[i] == nb[i][cur_p[i]]) begin cur_p[i]++; cur_b[i] = 0; end
                end
            end
            pending = (exp_q.size() != 0);
            for (int i = 0; i < NS; i++) if (cur_p[i] < npk[i]) pending = 1;
            cyc++;
        end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        #1;
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL %s timeout got %0d beats outstanding want 0", tag, exp_q.size());
        end
        checks++;
        if (drops_seen != exp_drop_beats) begin
            errors++;
            $display("FAIL %s dropped_beats got %0d want %0d", tag, drops_seen, exp_drop_beats);
        end
        checks++;
        if (cfg_err !== exp_cfg_err) begin
            errors++;
            $display("FAIL %s cfg_err got %b want %b", tag, cfg_err, exp_cfg_err);
        end
`ifdef PKT_SCHED_STATS_EN
        checks++;
        if (drop_cnt !== 16'(exp_drop_cnt)) begin
            errors++;
            $display("FAIL %s drop_cnt got %0d want %0d", tag, drop_cnt, exp_drop_cnt);
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (pkt_cnt[i*16 +: 16] !== 16'(exp_pkt[i])) begin
                errors++;
                $display("FAIL %s pkt_cnt[%0d] got %0d want %0d", tag, i, pkt_cnt[i*16 +: 16], exp_pkt[i]);
            end
        end
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({s_tready, m_tvalid, m_tlast, m_cfg, m_src, cfg_err} !== '0) begin
            errors++;
            $display("FAIL %s outputs got s_tready=%b m_tvalid=%b m_tlast=%b m_cfg=%h m_src=%0d cfg_err=%b want all 0",
                     tag, s_tready, m_tvalid, m_tlast, m_cfg, m_src, cfg_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; m_tready = 1'b1; s_tlast = '0;
        s_tvalid = NS'($urandom_range(1, 15));
        s_tdata = '0; s_cfg = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_zero_outputs("reset");
        s_tvalid = '0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check_zero_outputs("reset_release");
        clear_model();
    endtask

    task automatic test_rr_order();
        clear_traffic();
        add_pkt(0, 3, 8'd0, 8'd0, 16'h0000);
        add_pkt(1, 3, 8'd0, 8'd0, 16'h0000);
        add_pkt(2, 3, 8'd0, 8'd0, 16'h0000);
        add_pkt(3, 3, 8'd0, 8'd0, 16'h0000);
        add_pkt(0, 3, 8'd0, 8'd0, 16'h0000);
        run_traffic(0, 1'b0, 1'b1, "rr_order");
    endtask

    task automatic test_length_drop();
        clear_traffic();
        add_pkt(2, 6, 8'd2, 8'd4, 16'h0204);
        run_traffic(0, 1'b0, 1'b0, "length_drop");
    endtask

    task automatic test_backpressure();
        clear_traffic();
        add_pkt(1, 5, 8'd0, 8'd0, 16'hA5C3);
        run_traffic(1, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_cfg_change();
        clear_traffic();
        add_pkt(0, 4, 8'd1, 8'd8, 16'h0308);
        run_traffic(0, 1'b0, 1'b0, "cfg_change");
        clear_traffic();
        add_pkt(0, 3, 8'd9, 8'd8, 16'h0108);
        add_pkt(0, 2, 8'd1, 8'd8, 16'h0108);
        run_traffic(0, 1'b0, 1'b0, "cfg_err_sticky");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear_traffic();
            for (int s = 0; s < NS; s++) begin
                int np;
                np = $urandom_range(0, 3);
                if (s == it % NS && np == 0) np = 1;
                for (int p = 0; p < np; p++)
                    add_pkt(s, $urandom_range(1, 10), DW'($urandom_range(0, 10)),
                            DW'($urandom_range(0, 9)), 16'($urandom));
            end
            run_traffic(2, 1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_packet();
        int hs, cyc;
        clear_traffic();
        add_pkt(2, 2, 8'd0, 8'd0, 16'h0000);
        run_traffic(0, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        s_tvalid = 4'b0010; s_tlast = '0; m_tready = 1'b1;
        s_tdata[1*DW +: DW] = DW'($urandom_range(0, 255));
        s_cfg[1*2*DW +: 2*DW] = 16'h0908;
        hs = 0; cyc = 0;
        while (hs < 1 && cyc < 20) begin
            #1;
            if (m_tvalid && m_tready) hs++;
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (!(m_tvalid === 1'b1 && m_tlast === 1'b0 && m_src === 2'd1 && cfg_err === 1'b1)) begin
            errors++;
            $display("FAIL abort_inflight got m_tvalid=%b m_tlast=%b m_src=%0d cfg_err=%b want 1 0 1 1",
                     m_tvalid, m_tlast, m_src, cfg_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_tready, m_tvalid, m_tlast} !== '0) begin
            errors++;
            $display("FAIL abort_comb got s_tready=%b m_tvalid=%b m_tlast=%b want 0", s_tready, m_tvalid, m_tlast);
        end
        @(posedge clk); #1;
        check_zero_outputs("abort_edge");
        @(negedge clk);
        s_tvalid = '0;
        rst = 1'b1;
        @(negedge clk); #1;
        check_zero_outputs("abort_release");
        clear_model();
        clear_traffic();
        add_pkt(3, 2, 8'd0, 8'd0, 16'h0000);
        add_pkt(0, 2, 8'd0, 8'd0, 16'h0000);
        run_traffic(0, 1'b0, 1'b1, "after_abort");
    endtask

    initial begin
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_cfg = '0; m_tready = 1'b1; rst = 1'b0;
        clear_traffic();
        clear_model();
        test_reset();
        test_rr_order();
        test_length_drop();
        test_backpressure();
        test_cfg_change();
        test_random();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_sched.md
PKT_SCHED -- requirements
Module: pkt_sched

Interface
- REQ-001: Parameter DW, default 8, sets the data width and the width of each config field.
- REQ-002: Parameter NS, default 4, sets the number of AXI-stream sources; the legal range is 2..16.
- REQ-003: Localparam SW = $clog2(NS) sets the source-index width.
- REQ-004: clk  input  1  — single clock; all logic is rising-edge.
- REQ-005: rst  input  1  — synchronous, active-low reset.
- REQ-006: s_tdata  input  NS*DW  — per-source data; source i occupies bits [i*DW +: DW].
- REQ-007: s_tvalid, s_tlast  input  NS  — per-source valid and end-of-packet.
- REQ-008: s_tready  output  NS  — per-source ready.
- REQ-009: s_cfg  input  NS*2*DW  — per-source {k,len}; k occupies the upper DW bits.
- REQ-010: m_tdata, m_tvalid, m_tlast  output  DW,1,1  — stream towards the packet-add datapath.
- REQ-011: m_tready  input  1  — downstream ready.
- REQ-012: m_cfg  output  2*DW  — {k,len} of the granted source, held stable for the whole packet.
- REQ-013: m_src  output  SW  — index of the granted source.
- REQ-014: cfg_err  output  1  — sticky flag, set when a granted cfg has k > len.

Function
- REQ-015: The FSM SHALL have four states: IDLE, ARB, XFER, DROP.
- REQ-016: IDLE SHALL go to ARB on the cycle after any s_tvalid is seen high; all s_tready are 0 in IDLE.
- REQ-017: ARB SHALL grant in round-robin order, starting from the source after the last winner.
  - After reset, source 0 has the highest priority.
  - On the same edge, ARB latches m_cfg and m_src and enters XFER.
- REQ-018: If no s_tvalid is high in ARB, ARB SHALL return to IDLE without changing the pointer.
- REQ-019: In XFER the SHALL datapath be a pass-through of the granted source, with zero cycles of latency:
  - m_tdata = s_tdata[g], m_tvalid = s_tvalid[g], s_tready[g] = m_tready.
  - All other s_tready stay 0.
- REQ-020: A beat counter SHALL count m_tvalid & m_tready handshakes in XFER and be cleared in ARB.
- REQ-021: m_tlast SHALL equal s_tlast[g] OR (len != 0 AND beat == len-1).
- REQ-022: A handshake with s_tlast[g]=1 SHALL move XFER to IDLE and advance the pointer to g+1 (mod NS).
- REQ-023: A length-forced m_tlast without s_tlast[g] SHALL move XFER to DROP.
- REQ-024: DROP SHALL hold s_tready[g]=1 and m_tvalid=0, discarding beats until s_tlast[g] is accepted, then go to IDLE and advance the pointer.
- REQ-025: len == 0 SHALL mean no length limit.
- REQ-026: A source whose s_tvalid falls mid-packet SHALL keep the grant; there is no timeout.
- REQ-027: m_cfg and m_src SHALL NOT change between ARB and the exit from XFER or DROP.
- REQ-028: Every packet SHALL take at least 2 idle cycles (IDLE, ARB) before its first beat, so back-to-back packets are separated by 2 cycles.
- REQ-029: Changes to s_cfg while a packet is in flight SHALL have no effect until the next ARB.

Reset
- REQ-030: While rst=0 the following SHALL be 0: state (IDLE), pointer, beat counter, m_cfg, m_src, cfg_err, all s_tready, m_tvalid, m_tlast.
- REQ-031: Reset asserted mid-packet SHALL abort the packet with no partial m_tlast, and outputs SHALL be at reset values on the next edge.

Configuration
- REQ-032: When PKT_SCHED_STATS_EN is defined, the block SHALL add these outputs:
  - pkt_cnt  NS*16 — per-source completed-packet counters.
  - drop_cnt  16 — DROP entries.
  - Both are wrapping, cleared by reset, and increment on the XFER/DROP exit edge.
- REQ-033: When PKT_SCHED_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-034: Package pkt_sched_pkg SHALL hold:
  - the state enum (IDLE, ARB, XFER, DROP);
  - the cfg struct {k,len};
  - the counter width constant (16).
- REQ-035: Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer, output grant index and valid), reusable by other schedulers.

Verification
- REQ-036: NS=4, all four sources valid with 3-beat packets, m_tready=1 -> grants in order 0,1,2,3,0; each packet preceded by 2 idle cycles.
- REQ-037: Source 2 cfg {k=2,len=4} sends a 6-beat packet -> 4 beats out with m_tlast on beat 4; the remaining 2 beats are accepted with m_tvalid=0; drop_cnt=1 (stats enabled).
- REQ-038: m_tready toggles 1,0,1,0 during a 5-beat packet from source 1 -> no beat lost or duplicated; s_tready[1] mirrors m_tready; m_cfg stays stable.
- REQ-039: s_cfg[0] changed from {1,8} to {3,8} mid-packet -> m_cfg stays {1,8} until the next ARB; a cfg of {9,8} at ARB sets cfg_err=1 and it stays set.
- REQ-040: rst=0 asserted on beat 2 of a packet -> all outputs 0 on the next edge; after release, source 0 wins first.
